// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared Gray-code helpers and receiver FSM state type
package gray_pkg;

    localparam int GRAY_W = 4;
    localparam int MAX_W  = 32;

    typedef enum logic {
        PRIME = 1'b0,
        TRACK = 1'b1
    } rx_state_t;

    // Each binary bit is the XOR of its Gray bit and all higher ones; callers zero-extend.
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b = g;
        for (int i = 1; i < MAX_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_sync.sv
// rtl/gray_sync.sv - multi-stage flop synchronizer for a Gray-coded bus
module gray_sync #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/gray_rx_decoder.sv
// rtl/gray_rx_decoder.sv - synchronizes a Gray bus, decodes it and tracks signed step position
module gray_rx_decoder
    import gray_pkg::*;
#(
    parameter int WIDTH       = GRAY_W,
    parameter int SYNC_STAGES = 2,
    parameter int POS_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] bin_out,
    output logic             valid,
    output logic             dir,
    output logic [POS_W-1:0] pos,
    output logic             err_pulse,
    output logic             err
);

    localparam int CNT_W = $clog2(SYNC_STAGES + 1);

    rx_state_t        state, state_nxt;
    logic [CNT_W-1:0] prime_cnt, prime_cnt_nxt;
    logic [WIDTH-1:0] s_gray, s_bin, prev_gray, diff;
    logic [WIDTH-1:0] prev_gray_nxt, bin_out_nxt;
    logic [POS_W-1:0] pos_nxt;
    logic             valid_nxt, dir_nxt, err_pulse_nxt, err_nxt;
    logic             one_step, multi_step, step_up;

    gray_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (gray_in),
        .q     (s_gray)
    );

    assign s_bin      = WIDTH'(gray2bin(MAX_W'(s_gray)));
    assign diff       = s_gray ^ prev_gray;
    assign one_step   = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
    assign multi_step = (diff != '0) && !one_step;
    assign step_up    = (s_bin == bin_out + WIDTH'(1));

    // PRIME waits for the synchronizer to refill after reset so the first real
    // sample becomes the reference instead of being compared against reset zeros.
    always_comb begin
        state_nxt     = state;
        prime_cnt_nxt = prime_cnt;
        prev_gray_nxt = prev_gray;
        bin_out_nxt   = bin_out;
        pos_nxt       = pos;
        dir_nxt       = dir;
        valid_nxt     = 1'b0;
        err_pulse_nxt = 1'b0;
        err_nxt       = err & ~err_clr;
        case (state)
            PRIME: begin
                prev_gray_nxt = s_gray;
                bin_out_nxt   = s_bin;
                if (prime_cnt == CNT_W'(SYNC_STAGES)) begin
                    state_nxt = TRACK;
                end else begin
                    prime_cnt_nxt = prime_cnt + CNT_W'(1);
                end
            end
            TRACK: begin
                if (one_step) begin
                    prev_gray_nxt = s_gray;
                    bin_out_nxt   = s_bin;
                    valid_nxt     = 1'b1;
                    dir_nxt       = step_up;
                    pos_nxt       = step_up ? pos + POS_W'(1) : pos - POS_W'(1);
                end else if (multi_step) begin
                    prev_gray_nxt = s_gray;
                    bin_out_nxt   = s_bin;
                    err_pulse_nxt = 1'b1;
                    err_nxt       = 1'b1;
                end
            end
            default: state_nxt = PRIME;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= PRIME;
            prime_cnt <= '0;
            prev_gray <= '0;
            bin_out   <= '0;
            pos       <= '0;
            valid     <= 1'b0;
            dir       <= 1'b0;
            err_pulse <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            prime_cnt <= prime_cnt_nxt;
            prev_gray <= prev_gray_nxt;
            bin_out   <= bin_out_nxt;
            pos       <= pos_nxt;
            valid     <= valid_nxt;
            dir       <= dir_nxt;
            err_pulse <= err_pulse_nxt;
            err       <= err_nxt;
        end
    end

endmodule

// File: tb/tb_gray_rx_decoder.sv
// tb/tb_gray_rx_decoder.sv - scoreboard bench for gray_rx_decoder
module tb_gray_rx_decoder;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  gray_in;
    logic        err_clr;
    logic [3:0]  bin_out;
    logic        valid, dir, err_pulse, err;
    logic [15:0] pos;

    typedef struct {
        bit          is_err;
        logic [3:0]  bin;
        bit          dir;
        logic [15:0] pos;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [15:0] exp_pos  = '0;
    bit          exp_dir  = 1'b0;

    gray_rx_decoder #(.WIDTH(4), .SYNC_STAGES(2), .POS_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .gray_in   (gray_in),
        .err_clr   (err_clr),
        .bin_out   (bin_out),
        .valid     (valid),
        .dir       (dir),
        .pos       (pos),
        .err_pulse (err_pulse),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drives one Gray value, queues the expected event, then holds for 4 cycles total.
    task automatic step(input logic [3:0] g, input bit is_err, input logic [3:0] eb, input bit ed);
        @(posedge clk); #1;
        gray_in = g;
        if (!is_err) begin
            exp_dir = ed;
            exp_pos = ed ? exp_pos + 16'd1 : exp_pos - 16'd1;
        end
        sb.push_back('{is_err, eb, exp_dir, exp_pos, cyc + LAT});
        repeat (3) @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n && (valid || err_pulse)) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: valid=%0b err_pulse=%0b bin_out=%0h (cycle %0d)",
                         valid, err_pulse, bin_out, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("event_kind_err", 32'(err_pulse), 32'(e.is_err));
                chk("event_kind_valid", 32'(valid), 32'(!e.is_err));
                chk("event_bin_out", 32'(bin_out), 32'(e.bin));
                chk("event_dir", 32'(dir), 32'(e.dir));
                chk("event_pos", 32'(pos), 32'(e.pos));
                chk("event_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        gray_in = 4'b0110;
        err_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_bin_out", 32'(bin_out), 32'h0);
        chk("rst_pos", 32'(pos), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_dir", 32'(dir), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("prime_bin_out", 32'(bin_out), 32'h4);
        chk("prime_err", 32'(err), 32'h0);
        chk("prime_pos", 32'(pos), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("prime_err_late", 32'(err), 32'h0);

        // 0110 -> 0000 is a two-bit jump
        step(4'b0000, 1'b1, 4'h0, 1'b0);
        @(negedge clk);
        chk("jump_err_set", 32'(err), 32'h1);
        @(posedge clk); #1; err_clr = 1'b1;
        @(posedge clk); #1; err_clr = 1'b0;
        @(negedge clk);
        chk("err_clr", 32'(err), 32'h0);

        // up walk: bins 1, 2, 3
        step(4'b0001, 1'b0, 4'h1, 1'b1);
        step(4'b0011, 1'b0, 4'h2, 1'b1);
        step(4'b0010, 1'b0, 4'h3, 1'b1);
        @(negedge clk);
        chk("up_bin_out", 32'(bin_out), 32'h3);
        chk("up_pos", 32'(pos), 32'h3);

        // down walk to bin 0 then wrap down to 15; pos goes 3 -> 0xFFFF
        step(4'b0011, 1'b0, 4'h2, 1'b0);
        step(4'b0001, 1'b0, 4'h1, 1'b0);
        step(4'b0000, 1'b0, 4'h0, 1'b0);
        step(4'b1000, 1'b0, 4'hF, 1'b0);
        @(negedge clk);
        chk("pos_wrap_down", 32'(pos), 32'hFFFF);
        step(4'b0000, 1'b0, 4'h0, 1'b1);
        @(negedge clk);
        chk("pos_wrap_up", 32'(pos), 32'h0000);
        step(4'b1000, 1'b0, 4'hF, 1'b0);
        step(4'b0000, 1'b0, 4'h0, 1'b1);
        @(negedge clk);
        chk("wrap_pos_return", 32'(pos), 32'h0000);

        // illegal jump 0000 -> 0110
        step(4'b0110, 1'b1, 4'h4, 1'b0);
        @(negedge clk);
        chk("illegal_err", 32'(err), 32'h1);
        chk("illegal_bin_out", 32'(bin_out), 32'h4);
        chk("illegal_pos", 32'(pos), 32'h0);
        @(posedge clk); #1; err_clr = 1'b1;
        @(posedge clk); #1; err_clr = 1'b0;
        @(negedge clk);
        chk("err_clr_2", 32'(err), 32'h0);

        // err_clr sampled on the same edge the next jump is detected
        @(posedge clk); #1;
        gray_in = 4'b0000;
        sb.push_back('{1'b1, 4'h0, exp_dir, exp_pos, cyc + LAT});
        repeat (2) @(posedge clk);
        #1; err_clr = 1'b1;
        @(posedge clk); #1; err_clr = 1'b0;
        @(negedge clk);
        chk("err_set_wins", 32'(err), 32'h1);
        repeat (2) @(posedge clk);

        // walk to pos = 5, then reset while the input changes
        step(4'b0001, 1'b0, 4'h1, 1'b1);
        step(4'b0011, 1'b0, 4'h2, 1'b1);
        step(4'b0010, 1'b0, 4'h3, 1'b1);
        step(4'b0110, 1'b0, 4'h4, 1'b1);
        step(4'b0111, 1'b0, 4'h5, 1'b1);
        @(negedge clk);
        chk("pre_reset_pos", 32'(pos), 32'h5);
        @(posedge clk); #1;
        rst_n   = 1'b0;
        gray_in = 4'b0101;
        @(posedge clk); #1;
        rst_n   = 1'b1;
        exp_pos = '0;
        exp_dir = 1'b0;
        @(negedge clk);
        chk("midrst_pos", 32'(pos), 32'h0);
        chk("midrst_err", 32'(err), 32'h0);
        chk("midrst_valid", 32'(valid), 32'h0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("midrst_prime_bin", 32'(bin_out), 32'h6);
        chk("midrst_prime_err", 32'(err), 32'h0);
        step(4'b0111, 1'b0, 4'h5, 1'b0);
        @(negedge clk);
        chk("post_reset_pos", 32'(pos), 32'hFFFF);

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
